// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch stage
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'hE1A0_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fetch_queue.sv
// rtl/ifetch_fetch_queue.sv - flushable FIFO of fetched {pc, instr} entries
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != FULL) | do_pop);
    assign head    = mem_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !(reset || flush))
            mem_q[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - fetch PC, imem req/ack handshake and decode-facing instruction queue
// Optional IFETCH_PERF_EN adds FetchCount/BubbleCount performance counters.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRData,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus8F,
`ifdef IFETCH_PERF_EN
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount,
`endif
    output logic        ValidF
);

    localparam int            CW   = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [31:0]   pc_q;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          push;
    logic          pop;

    // Eligibility uses the pre-pop count; a full queue draining this cycle still bubbles.
    assign ImemReq  = ~reset & ~Redirect & (count < FULL);
    assign ImemAddr = pc_q;
    assign push     = ImemReq & ImemAck;
    assign pop      = ValidF & ~stall;

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = ImemRData;

    // Decode outputs come only from registered queue/PC state, never from stall.
    assign ValidF   = (count != '0);
    assign InstrF   = ValidF ? head.instr : NOP_INSTR;
    assign PCPlus8F = ValidF ? (head.pc + 32'd8) : (pc_q + 32'd8);

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (Redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= RESET_PC;
        else if (Redirect)
            pc_q <= RedirectPC;
        else if (push)
            pc_q <= pc_q + 32'd4;
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            FetchCount  <= '0;
            BubbleCount <= '0;
        end else begin
            if (push)
                FetchCount <= FetchCount + 32'd1;
            if (!ValidF && !stall)
                BubbleCount <= BubbleCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed and randomized checks of ifetch against a queue-level model
module tb_ifetch;
    import ifetch_pkg::*;

    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, Redirect, ImemAck, ImemReq, ValidF;
    logic [31:0] RedirectPC, ImemAddr, ImemRData, InstrF, PCPlus8F;
`ifdef IFETCH_PERF_EN
    logic [31:0] FetchCount, BubbleCount;
`endif

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemAck    (ImemAck),
        .ImemRData  (ImemRData),
        .InstrF     (InstrF),
        .PCPlus8F   (PCPlus8F),
`ifdef IFETCH_PERF_EN
        .FetchCount (FetchCount),
        .BubbleCount(BubbleCount),
`endif
        .ValidF     (ValidF)
    );

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] seed;
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ seed ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare, advance the model, return at next negedge.
    task automatic cycle(input logic rst, input logic st, input logic ak, input logic rd,
                         input logic [31:0] rpc);
        logic exp_req, valid, push, pop;
        reset = rst; stall = st; ImemAck = ak; Redirect = rd; RedirectPC = rpc;
        #1;
        ImemRData = mem_word(ImemAddr);
        #1;
        exp_req = !rst && !rd && (m_q.size() < QD);
        valid   = (m_q.size() > 0);
        check("ImemReq", {31'b0, ImemReq}, {31'b0, exp_req});
        if (!rst) begin
            check("ValidF", {31'b0, ValidF}, {31'b0, valid});
            check("InstrF", InstrF, valid ? mem_word(m_q[0]) : NOP_INSTR);
            check("PCPlus8F", PCPlus8F, valid ? m_q[0] + 32'd8 : m_pc + 32'd8);
            if (exp_req) check("ImemAddr", ImemAddr, m_pc);
`ifdef IFETCH_PERF_EN
            check("FetchCount", FetchCount, m_fetch);
            check("BubbleCount", BubbleCount, m_bubble);
`endif
        end
        push = exp_req && ak;
        pop  = valid && !st;
        if (rst) begin
            m_pc = RPC; m_q.delete(); m_fetch = 0; m_bubble = 0;
        end else begin
            if (!valid && !st) m_bubble++;
            if (rd) begin
                m_q.delete();
                m_pc = rpc;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                    m_fetch++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int wc;
        logic [31:0] rpc;
        seed = $urandom;
        m_pc = RPC; m_fetch = 0; m_bubble = 0;
        reset = 1'b1; stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        ImemAck = 1'b0; ImemRData = '0;
        @(negedge clk);

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("reset_valid", {31'b0, ValidF}, 32'd0);
        check("reset_instr", InstrF, NOP_INSTR);
        check("reset_pc8", PCPlus8F, RPC + 32'd8);
        check("first_addr", ImemAddr, 32'h0);

        // Zero-wait memory
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0, 0);
            check("zw_valid", {31'b0, ValidF}, 32'd1);
            check("zw_pc8", PCPlus8F, 32'h8 + 32'(4 * i));
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);

        // Two wait states per word
        wc = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(0, 0, (wc == 2), 0, 0);
            wc = (wc == 2) ? 0 : wc + 1;
        end

        // Stall fills the queue, request drops, then drains in order
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0);
        check("full_req", {31'b0, ImemReq}, 32'd0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0, 0);

        // Redirect with a full queue and a same-cycle ack
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 1, 1, 32'h100);
        check("redir_bubble", {31'b0, ValidF}, 32'd0);
        check("redir_addr", ImemAddr, 32'h100);
        cycle(0, 0, 1, 0, 0);
        check("redir_instr", InstrF, mem_word(32'h100));
        check("redir_pc8", PCPlus8F, 32'h108);
        cycle(0, 0, 1, 0, 0);

        // PC wrap
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 1, 0, 0);
        check("wrap_addr", ImemAddr, 32'h0);
        check("wrap_pc8", PCPlus8F, 32'h4);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rpc = {$urandom, 2'b00};
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | {28'b0, rpc[3:2], 2'b00};
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), rpc);
        end

`ifdef IFETCH_PERF_EN
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0);
        check("perf_fetch", FetchCount, 32'd10);
        check("perf_bubble", BubbleCount, 32'd3);
        cycle(1, 0, 0, 0, 0);
        check("perf_fetch_rst", FetchCount, 32'd0);
        check("perf_bubble_rst", BubbleCount, 32'd0);
`endif

        cycle(0, 0, 1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
